// File: rtl/crc_pkg.sv
// Shared constants and types for the nibble-wide CRC-16 (0x1021) datapath.
// Latency: n/a (package).
// Backpressure: n/a (package).
package crc_pkg;

  localparam int NIB_W   = 4;
  localparam int CRC16_W = 16;

  typedef logic [NIB_W-1:0]   nib_t;
  typedef logic [CRC16_W-1:0] crc16_t;

  localparam crc16_t CRC16_POLY    = 16'h1021;
  // Register value after clocking in a frame together with its own CRC.
  localparam crc16_t CRC16_RESIDUE = 16'h0000;

endpackage

// File: rtl/crc16_nib_step.sv
// One nibble step of CRC-16/0x1021, MSB-first (data bit 3 enters first).
// Latency: purely combinational.
// Backpressure: none; ports: data (nibble in), crc (current state), crc_next (next state).
module crc16_nib_step
  import crc_pkg::*;
(
  input  nib_t   data,
  input  crc16_t crc,
  output crc16_t crc_next
);

  // The four feedback bits are independent: a feedback injected at bit 12
  // reaches bit 15 only after the fourth shift, so it never feeds back
  // within the same nibble. crc_next = (crc << 4) ^ f*0x1021.
  logic [3:0] f;

  always_comb begin
    f              = data ^ crc[15:12];
    crc_next       = '0;
    crc_next[3:0]  = f;
    crc_next[4]    = crc[0];
    crc_next[8:5]  = crc[4:1] ^ f;
    crc_next[11:9] = crc[7:5];
    crc_next[15:12] = crc[11:8] ^ f;
  end

endmodule

// File: rtl/crc16_nib_chk.sv
// Receive-side CRC-16 nibble checker: strips the 4-nibble CRC trailer, forwards payload, pulses per-frame status.
// Latency: payload nibble appears 1 cycle after the beat that pushes it out of the 4-deep delay line; status 1 cycle after last.
// Backpressure: s_ready_o drops only when the delay line is full, the output register is full and m_ready_i is low.
// Ports: s_* nibble input stream, m_* payload output stream, stat_* per-frame result (pulse + held flags/residue).
module crc16_nib_chk
  import crc_pkg::*;
#(
  parameter crc16_t INIT = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [3:0]  s_data_i,
  input  logic        s_last_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [3:0]  m_data_o,
  output logic        m_last_o,
  output logic        stat_valid_o,
  output logic        stat_pass_o,
  output logic        stat_short_o,
  output logic        stat_empty_o,
  output logic [15:0] stat_residue_o
);

  // Delay line holding back the last four nibbles (possible CRC field).
  // fifo_q[0] is the oldest entry.
  nib_t       fifo_q [4];
  logic [2:0] count;
  crc16_t     crc;
  crc16_t     crc_next;
  logic       full;
  logic       acc;
  logic       fwd;

  crc16_nib_step u_step (
    .data     (s_data_i),
    .crc      (crc),
    .crc_next (crc_next)
  );

  assign full      = (count == 3'd4);
  // Output register can take a new nibble if it is empty or draining now.
  assign s_ready_o = !full || !m_valid_o || m_ready_i;
  assign acc       = s_valid_i && s_ready_o;
  assign fwd       = acc && full;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      count          <= '0;
      crc            <= INIT;
      m_valid_o      <= 1'b0;
      m_data_o       <= '0;
      m_last_o       <= 1'b0;
      stat_valid_o   <= 1'b0;
      stat_pass_o    <= 1'b0;
      stat_short_o   <= 1'b0;
      stat_empty_o   <= 1'b0;
      stat_residue_o <= '0;
    end else begin
      stat_valid_o <= acc && s_last_i;

      if (fwd) begin
        m_valid_o <= 1'b1;
        m_data_o  <= fifo_q[0];
        m_last_o  <= s_last_i;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end

      if (acc) begin
        // Pushing on the last beat is harmless: the line is cleared anyway.
        if (full) begin
          fifo_q[0] <= fifo_q[1];
          fifo_q[1] <= fifo_q[2];
          fifo_q[2] <= fifo_q[3];
          fifo_q[3] <= s_data_i;
        end else begin
          fifo_q[count[1:0]] <= s_data_i;
        end

        if (s_last_i) begin
          // count holds length-1 here (saturated at 4 for long frames).
          count          <= '0;
          crc            <= INIT;
          stat_residue_o <= crc_next;
          stat_short_o   <= (count < 3'd3);
          stat_empty_o   <= (count == 3'd3);
          stat_pass_o    <= (crc_next == CRC16_RESIDUE) && (count >= 3'd3);
        end else begin
          count <= full ? count : count + 3'd1;
          crc   <= crc_next;
        end
      end
    end
  end

endmodule
